// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: 8N1 UART receiver.
//   Synchronises the asynchronous rx_i line into clk_i, finds the start-bit
//   falling edge, samples each bit at its centre and emits one byte per frame.
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous, active-high reset
//   rx_i         serial input, idles high
//   data_o       last correctly framed byte (LSB = first data bit)
//   data_v_o     1-cycle strobe, data_o updated this cycle
//   frame_err_o  1-cycle strobe, stop bit sampled low
//   busy_o       high while a frame is in progress
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       data_v_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CntLast = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CntHalf = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_prev_q;
  logic                   fall;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_q, data_d;
  logic                   data_v_q, data_v_d;
  logic                   ferr_q, ferr_d;
  logic                   cnt_last;

  // Sync flops reset to 1 so the line is assumed idle out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rx_prev_q <= rx_s;
    end
  end

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign fall     = rx_prev_q & ~rx_s;
  assign cnt_last = (cnt_q == CntLast);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    data_v_d = 1'b0;
    ferr_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (fall) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          // A start bit that is high again at its centre was a glitch.
          state_d = rx_s ? StIdle : StData;
          cnt_d   = '0;
          bit_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_last) begin
          cnt_d          = '0;
          shift_d[bit_q] = rx_s;
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d   = shift_q;
            data_v_d = 1'b1;
            state_d  = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StBreak: begin
        // Hold off until the line returns high so a stuck-low line cannot retrigger.
        cnt_d = '0;
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      data_q   <= 8'h00;
      data_v_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      data_v_q <= data_v_d;
      ferr_q   <= ferr_d;
    end
  end

  assign data_o      = data_q;
  assign data_v_o    = data_v_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int Cpb = 104;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       rx_i;
  logic [7:0] data_o;
  logic       data_v_o;
  logic       frame_err_o;
  logic       busy_o;

  uart_rx #(.CLKS_PER_BIT(104), .SYNC_STAGES(2)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .rx_i       (rx_i),
    .data_o     (data_o),
    .data_v_o   (data_v_o),
    .frame_err_o(frame_err_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   strobe_cyc[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   t_start;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    n_checks++;
    if (got >= lo && got <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
  endtask

  // Scoreboard monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst_i && (data_v_o || frame_err_o)) begin
      exp_t e;
      check("strobe_exclusive", {31'b0, data_v_o & frame_err_o}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {30'b0, data_v_o, frame_err_o}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_is_err", {31'b0, frame_err_o}, {31'b0, e.err});
        check("strobe_data", {24'b0, data_o}, {24'b0, e.data});
        strobe_cyc.push_back(cyc);
      end
    end
  end

  // Caller is just after a rising edge; returns just after a rising edge.
  task automatic drive_bit(input logic v, input int n);
    rx_i = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int n, input logic stop);
    t_start = cyc;
    drive_bit(1'b0, n);
    for (int i = 0; i < 8; i++) drive_bit(b[i], n);
    drive_bit(stop, n);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check(name, exp_q.size(), 32'd0);
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    rx_i  = 1'b1;
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data", {24'b0, data_o}, 32'h00);
    check("rst_data_v", {31'b0, data_v_o}, 32'd0);
    check("rst_frame_err", {31'b0, frame_err_o}, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    idle(20);

    // 1: single byte, latency from start edge to strobe
    strobe_cyc.delete();
    exp_q.push_back('{err: 1'b0, data: 8'h21});
    send_frame(8'h21, Cpb, 1'b1);
    wait_drain("t1_drain");
    check("t1_count", strobe_cyc.size(), 32'd1);
    if (strobe_cyc.size() > 0) check_range("t1_latency", strobe_cyc[0] - t_start, 989, 993);
    idle(2 * Cpb);

    // 2: 20-cycle glitch low
    rx_i = 1'b0;
    t_start = cyc;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t2_busy_during", {31'b0, busy_o}, 32'd1);
    @(posedge clk);
    #1;
    repeat (9) @(posedge clk);
    #1;
    rx_i = 1'b1;
    repeat (cyc < t_start + 62 ? t_start + 62 - cyc : 0) @(posedge clk);
    @(negedge clk);
    check("t2_busy_dropped", {31'b0, busy_o}, 32'd0);
    @(posedge clk);
    #1;
    idle(2 * Cpb);

    // 3: framing error from a clean reset, long break, then recovery
    pulse_reset();
    @(negedge clk);
    check("t3_data_after_rst", {24'b0, data_o}, 32'h00);
    @(posedge clk);
    #1;
    idle(Cpb);
    exp_q.push_back('{err: 1'b1, data: 8'h00});
    send_frame(8'h00, Cpb, 1'b0);
    repeat (1000) @(posedge clk);
    @(negedge clk);
    check("t3_busy_in_break", {31'b0, busy_o}, 32'd1);
    repeat (960) @(posedge clk);
    #1;
    wait_drain("t3_err_drain");
    idle(5 * Cpb);
    check("t3_busy_idle", {31'b0, busy_o}, 32'd0);
    check("t3_data_held", {24'b0, data_o}, 32'h00);
    exp_q.push_back('{err: 1'b0, data: 8'h55});
    send_frame(8'h55, Cpb, 1'b1);
    wait_drain("t3_drain");
    idle(2 * Cpb);

    // 4: back-to-back frames
    strobe_cyc.delete();
    exp_q.push_back('{err: 1'b0, data: 8'hA5});
    exp_q.push_back('{err: 1'b0, data: 8'h5A});
    exp_q.push_back('{err: 1'b0, data: 8'hFF});
    send_frame(8'hA5, Cpb, 1'b1);
    send_frame(8'h5A, Cpb, 1'b1);
    send_frame(8'hFF, Cpb, 1'b1);
    wait_drain("t4_drain");
    check("t4_count", strobe_cyc.size(), 32'd3);
    if (strobe_cyc.size() == 3) begin
      check_range("t4_gap1", strobe_cyc[1] - strobe_cyc[0], 10 * Cpb - 1, 10 * Cpb + 1);
      check_range("t4_gap2", strobe_cyc[2] - strobe_cyc[1], 10 * Cpb - 1, 10 * Cpb + 1);
    end
    idle(2 * Cpb);

    // 5: reset in the middle of bit 4 of 0x3C; the sender abandons that frame
    drive_bit(1'b0, Cpb);
    drive_bit(1'b0, Cpb);
    drive_bit(1'b0, Cpb);
    drive_bit(1'b1, Cpb);
    drive_bit(1'b1, Cpb);
    rx_i = 1'b1;
    repeat (Cpb / 2) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(negedge clk);
    check("t5_rst_data", {24'b0, data_o}, 32'h00);
    check("t5_rst_busy", {31'b0, busy_o}, 32'd0);
    check("t5_rst_strobes", {30'b0, data_v_o, frame_err_o}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    idle(20 * Cpb);
    check("t5_idle_busy", {31'b0, busy_o}, 32'd0);
    exp_q.push_back('{err: 1'b0, data: 8'h3C});
    send_frame(8'h3C, Cpb, 1'b1);
    wait_drain("t5_drain");
    idle(2 * Cpb);

    // 6: +/-3% baud error
    exp_q.push_back('{err: 1'b0, data: 8'h96});
    send_frame(8'h96, 107, 1'b1);
    wait_drain("t6_slow_drain");
    idle(2 * Cpb);
    exp_q.push_back('{err: 1'b0, data: 8'h96});
    send_frame(8'h96, 101, 1'b1);
    wait_drain("t6_fast_drain");
    idle(4 * Cpb);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation exceeded 60000 cycles");
    $fatal(1, "watchdog");
  end

endmodule
